// File: rtl/vga_pkg.sv
// Shared constants, types and the framebuffer address helper for the
// VGA framebuffer arbiter.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        DRAIN
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_t;

    // y*640 + x as two shifts and an add, so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = {{(ADDR_W-10){1'b0}}, y};
        xw = {{(ADDR_W-10){1'b0}}, x};
        return (yw << 9) + (yw << 7) + xw;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that queues pixel writes until the RAM port is
// free during blanking.
module fb_wr_fifo
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  fb_wr_t din,
    output fb_wr_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fb_wr_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between VGA scan-out (owner
// during the active region) and a queued pixel writer (drained in blanking).
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        cuentaX,
    input  logic [9:0]        cuentaY,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid,
    output logic              addr_err
);

    fb_state_t         state_q, state_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    fb_wr_t            fifo_din, fifo_dout;
    logic              active, wr_in_range, wr_accept;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic [1:0]        act_pipe_q, act_pipe_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              addr_err_q, addr_err_d;

    assign active      = (cuentaX < 10'(H_ACTIVE)) && (cuentaY < 10'(V_ACTIVE));
    assign wr_in_range = (wr_x < 10'(H_ACTIVE)) && (wr_y < 10'(V_ACTIVE));
    assign wr_ready    = ~fifo_full;
    assign wr_accept   = wr_valid & ~fifo_full;
    assign fifo_push   = wr_accept & wr_in_range;
    assign fifo_din    = '{addr: fb_addr(wr_x, wr_y), data: wr_data};

    fb_wr_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = IDLE;
        fifo_pop    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (active) begin
            state_d = DISP;
        end else if (!fifo_empty) begin
            state_d = DRAIN;
        end

        // RAM command is chosen from the next state and registered with it.
        case (state_d)
            DISP: begin
                mem_addr_d = fb_addr(cuentaX, cuentaY);
            end
            DRAIN: begin
                fifo_pop    = 1'b1;
                mem_addr_d  = fifo_dout.addr;
                mem_wdata_d = fifo_dout.data;
            end
            default: ;
        endcase

        act_pipe_d    = {act_pipe_q[0], active};
        pixel_valid_d = act_pipe_q[1];
        pixel_d       = act_pipe_q[1] ? mem_rdata : '0;
        addr_err_d    = addr_err_q | (wr_accept & ~wr_in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            act_pipe_q    <= '0;
            pixel_valid_q <= 1'b0;
            pixel_q       <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            act_pipe_q    <= act_pipe_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_q       <= pixel_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign mem_we      = (state_q == DRAIN);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign addr_err    = addr_err_q;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (640x480, 8-bit pixels) between two users:
  - VGA scan-out reads.
  - A pixel writer (drawing logic) using a valid/ready handshake.
- Scan-out owns the port whenever the VGA position is in the active region.
- Writes are queued in a small FIFO and drained during horizontal/vertical blanking.
- Sits between the VGA controller's cuentaX/cuentaY counters, the framebuffer RAM and the colour output path.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- DATA_W, 8, pixel width
- ADDR_W, 19, framebuffer address width (covers 307200 words)
- FIFO_DEPTH, 4, write-queue entries (power of two)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous active-high reset
- cuentaX  in  10  current horizontal position from VGA controller
- cuentaY  in  10  current vertical position from VGA controller
- wr_valid  in  1  writer presents a pixel write
- wr_ready  out  1  FIFO can accept a write this cycle
- wr_x  in  10  write column
- wr_y  in  10  write row
- wr_data  in  DATA_W  write pixel value
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address
- pixel  out  DATA_W  scan-out pixel, 0 when not valid
- pixel_valid  out  1  pixel corresponds to an active position
- addr_err  out  1  sticky flag: an out-of-range write was accepted and dropped

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named rst.
- Reset values: FIFO empty, state IDLE, pixel=0, pixel_valid=0, addr_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- active = (cuentaX < H_ACTIVE) & (cuentaY < V_ACTIVE), evaluated combinationally each cycle.
- Address formula: addr = y*640 + x, computed as (y<<9)+(y<<7)+x, zero-extended to ADDR_W. No multiplier.
- Handshake:
  - wr_ready = ~fifo_full.
  - A write is accepted when wr_valid & wr_ready.
  - wr_ready does not depend on a same-cycle pop; there is no pass-through when full.
  - Out-of-range writes (wr_x>=640 or wr_y>=480) are accepted but not enqueued, and addr_err is set.
- FSM states:
  - IDLE: not active, FIFO empty.
  - DISP: active, port owned by scan-out.
  - DRAIN: not active, FIFO non-empty.
- FSM transitions:
  - Next state is a function of active and FIFO empty only. active takes priority over everything: DISP whenever active.
  - Otherwise DRAIN if FIFO non-empty, else IDLE.
- Port outputs are registered and driven from the next-state decision, so the RAM sees at most one command per cycle:
  - DISP: mem_we=0, mem_addr = address of (cuentaX, cuentaY) from the same cycle.
  - DRAIN: pop one FIFO entry per cycle; mem_we=1 with that entry's addr/data.
  - IDLE: mem_we=0, mem_addr holds its previous value.
- Scan-out pipeline, fixed latency 3 cycles from position to pixel:
  - cycle 0: position presented.
  - cycle 1: mem_addr registered.
  - cycle 2: mem_rdata returns.
  - cycle 3: pixel/pixel_valid registered.
  - The top level delays H_SYNC/V_SYNC/SYNC_BLANK by 3 cycles to align.
- pixel_valid is active delayed 3 cycles. pixel = pixel_valid ? captured mem_rdata : 0.
- Boundaries:
  - Simultaneous push and pop in DRAIN: count unchanged.
  - Push while FIFO full: not accepted (wr_ready=0).
  - Active region begins while FIFO non-empty: draining pauses, entries are retained, and draining resumes at the next blanking.
  - FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
  - rst mid-drain: queued writes are discarded and the pipeline is flushed (pixel_valid=0 the next cycle).
- Throughput: horizontal blanking is 160 cycles per line, so a sustained write rate up to 160 pixels per line is guaranteed lossless with backpressure.

Decomposition:
- Package vga_pkg holds:
  - constants H_ACTIVE/V_ACTIVE/DATA_W/ADDR_W;
  - typedef enum logic [1:0] {IDLE, DISP, DRAIN} fb_state_t;
  - typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} fb_wr_t.
- One sub-module: fb_wr_fifo, a synchronous FIFO of fb_wr_t with push/pop/full/empty/count.
- Address computation is a function in vga_pkg, shared by the write and read paths.

Test Plan:
- Reset with rst=1 for 2 cycles, mid-frame -> all outputs 0, wr_ready=1, state IDLE.
- Write (x=5, y=2, data=0xA5) issued at cuentaX=700 (blanking) -> next cycle mem_we=1, mem_addr=1285, mem_wdata=0xA5.
- Write issued during active region at (cuentaX=100, cuentaY=10) -> held in FIFO with no mem_we during active; written at the first blanking cycle, cuentaX=640.
- 5 back-to-back writes during the active region with FIFO_DEPTH=4 -> wr_ready drops after 4 accepts; the 5th is accepted on the first drain cycle; all 5 reach RAM in order.
- RAM model preloaded with addr 0=0x11, addr 1=0x22; scan from (0,0) -> pixel=0x11 with pixel_valid=1 three cycles after cuentaX=0, then 0x22; pixel=0 and pixel_valid=0 three cycles after cuentaX=640.
- Write to (640, 0) -> accepted, no mem_we, addr_err=1 and stays set until rst.
